// File: rtl/mac_job_arbiter_pkg.sv
// mac_job_arbiter_pkg: shared types for the MAC job arbiter.
// Holds the job descriptor, its width and the arbiter state encoding.
package mac_job_arbiter_pkg;

   typedef struct packed {
      logic [31:0] a_addr;
      logic [31:0] b_addr;
      logic [31:0] c_addr;
      logic [31:0] d_addr;
      logic [15:0] len;
      logic [4:0]  shift;
      logic        simple_mul;
   } mac_job_t;

   localparam int JOB_W = $bits(mac_job_t);

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_LAUNCH,
      ARB_BUSY,
      ARB_RESP
   } arb_state_t;

   // A zero-length job is illegal and is answered with an error.
   function automatic logic job_is_empty(mac_job_t j);
      return j.len == 16'd0;
   endfunction

endpackage

// File: rtl/mac_job_arbiter_if.sv
// mac_job_arbiter_if: requester job/response bus plus MAC start/done bus.
// slave = arbiter side, master = requesters + MAC side.
interface mac_job_arbiter_if #(
   parameter int N_REQ = 4
);
   import mac_job_arbiter_pkg::*;

   logic [N_REQ-1:0]       req_valid_i;
   logic [N_REQ-1:0]       req_ready_o;
   logic [N_REQ*JOB_W-1:0] req_job_i;
   logic [N_REQ-1:0]       rsp_valid_o;
   logic                   rsp_err_o;
   mac_job_t               mac_job_o;
   logic                   mac_start_o;
   logic                   mac_clear_o;
   logic                   mac_done_i;

   modport slave (
      input  req_valid_i, req_job_i, mac_done_i,
      output req_ready_o, rsp_valid_o, rsp_err_o,
      output mac_job_o, mac_start_o, mac_clear_o
   );

   modport master (
      output req_valid_i, req_job_i, mac_done_i,
      input  req_ready_o, rsp_valid_o, rsp_err_o,
      input  mac_job_o, mac_start_o, mac_clear_o
   );

endinterface

// File: rtl/mac_rr_arbiter.sv
// mac_rr_arbiter: combinational round-robin pick starting at ptr_i.
// Ports: req_i, ptr_i in; gnt_o (one-hot), gnt_idx_o, any_o out.
module mac_rr_arbiter #(
   parameter  int N_REQ = 4,
   localparam int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [N_REQ-1:0] gnt_o,
   output logic [IDX_W-1:0] gnt_idx_o,
   output logic             any_o
);

   always_comb begin
      gnt_o     = '0;
      gnt_idx_o = '0;
      any_o     = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (!any_o && req_i[(int'(ptr_i) + i) % N_REQ]) begin
            any_o = 1'b1;
            gnt_idx_o = IDX_W'((int'(ptr_i) + i) % N_REQ);
            gnt_o[(int'(ptr_i) + i) % N_REQ] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mac_job_arbiter.sv
// mac_job_arbiter: shares one MAC engine between N_REQ job requesters.
// Ports: clk_i, rst_i, clear_i; bus (jobs/responses/MAC start-done);
// busy_o, owner_o, done_cnt_o, err_cnt_o status outputs.
module mac_job_arbiter
   import mac_job_arbiter_pkg::*;
#(
   parameter  int N_REQ          = 4,
   parameter  int TIMEOUT_CYCLES = 65535,
   parameter  int CNT_W          = 16,
   localparam int IDX_W          = $clog2(N_REQ)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clear_i,
   mac_job_arbiter_if.slave bus,
   output logic             busy_o,
   output logic [IDX_W-1:0] owner_o,
   output logic [CNT_W-1:0] done_cnt_o,
   output logic [CNT_W-1:0] err_cnt_o
);

   localparam int WD_W = (TIMEOUT_CYCLES > 1) ?
                         $clog2(TIMEOUT_CYCLES) : 1;

   arb_state_t       state_q;
   logic [IDX_W-1:0] ptr_q;
   logic [IDX_W-1:0] owner_q;
   mac_job_t         job_q;
   logic             err_q;
   logic [WD_W-1:0]  wd_q;
   logic [CNT_W-1:0] done_cnt_q;
   logic [CNT_W-1:0] err_cnt_q;

   logic [N_REQ-1:0] gnt;
   logic [IDX_W-1:0] gnt_idx;
   logic             gnt_any;
   logic [N_REQ-1:0] ready;
   logic             xfer;
   mac_job_t         sel_job;
   logic             wd_hit;
   logic             resp_act;

   mac_rr_arbiter #(
      .N_REQ (N_REQ)
   ) u_rr (
      .req_i     (bus.req_valid_i),
      .ptr_i     (ptr_q),
      .gnt_o     (gnt),
      .gnt_idx_o (gnt_idx),
      .any_o     (gnt_any)
   );

   always_comb begin
      ready = '0;
      if (state_q == ARB_IDLE && !clear_i && !rst_i && gnt_any)
         ready = gnt;
      xfer    = |ready;
      sel_job = bus.req_job_i[int'(gnt_idx)*JOB_W +: JOB_W];
      // Done arriving on the timeout cycle wins over the abort.
      wd_hit  = (TIMEOUT_CYCLES != 0) && (state_q == ARB_BUSY) &&
                !bus.mac_done_i &&
                (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
      resp_act = (state_q == ARB_RESP) && !clear_i && !rst_i;
   end

   assign bus.req_ready_o = ready;
   assign bus.mac_job_o   = job_q;
   assign bus.mac_start_o = (state_q == ARB_LAUNCH) && !clear_i && !rst_i;
   assign bus.rsp_valid_o = resp_act ?
                            ({{(N_REQ-1){1'b0}}, 1'b1} << owner_q) : '0;
   assign bus.rsp_err_o   = resp_act && err_q;

   always_comb begin
      bus.mac_clear_o = 1'b0;
      if (!rst_i) begin
         if (clear_i)
            bus.mac_clear_o = (state_q == ARB_LAUNCH) ||
                              (state_q == ARB_BUSY);
         else
            bus.mac_clear_o = wd_hit;
      end
   end

   assign busy_o     = state_q != ARB_IDLE;
   assign owner_o    = owner_q;
   assign done_cnt_o = done_cnt_q;
   assign err_cnt_o  = err_cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ARB_IDLE;
         ptr_q      <= '0;
         owner_q    <= '0;
         job_q      <= '0;
         err_q      <= 1'b0;
         wd_q       <= '0;
         done_cnt_q <= '0;
         err_cnt_q  <= '0;
      end else if (clear_i) begin
         state_q <= ARB_IDLE;
      end else begin
         case (state_q)
            ARB_IDLE: begin
               if (xfer) begin
                  job_q   <= sel_job;
                  owner_q <= gnt_idx;
                  ptr_q   <= (gnt_idx == IDX_W'(N_REQ - 1)) ?
                             '0 : gnt_idx + 1'b1;
                  if (job_is_empty(sel_job)) begin
                     err_q   <= 1'b1;
                     state_q <= ARB_RESP;
                  end else begin
                     state_q <= ARB_LAUNCH;
                  end
               end
            end
            ARB_LAUNCH: begin
               wd_q    <= '0;
               state_q <= ARB_BUSY;
            end
            ARB_BUSY: begin
               wd_q <= wd_q + 1'b1;
               if (bus.mac_done_i) begin
                  err_q   <= 1'b0;
                  state_q <= ARB_RESP;
               end else if (wd_hit) begin
                  err_q   <= 1'b1;
                  state_q <= ARB_RESP;
               end
            end
            ARB_RESP: begin
               if (err_q) begin
                  if (err_cnt_q != '1)
                     err_cnt_q <= err_cnt_q + 1'b1;
               end else begin
                  if (done_cnt_q != '1)
                     done_cnt_q <= done_cnt_q + 1'b1;
               end
               state_q <= ARB_IDLE;
            end
            default: state_q <= ARB_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mac_job_arbiter.sv
// tb_mac_job_arbiter: directed + random jobs against a transaction model.
// Model tracks RR pointer, expected grant, latency and counters.
module tb_mac_job_arbiter;
   import mac_job_arbiter_pkg::*;

   localparam int N  = 4;
   localparam int TO = 16;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          clr;
   logic          busy;
   logic [1:0]    owner;
   logic [CW-1:0] dcnt;
   logic [CW-1:0] ecnt;

   always #5 clk = ~clk;

   mac_job_arbiter_if #(.N_REQ(N)) bus ();

   mac_job_arbiter #(
      .N_REQ          (N),
      .TIMEOUT_CYCLES (TO),
      .CNT_W          (CW)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .clear_i    (clr),
      .bus        (bus),
      .busy_o     (busy),
      .owner_o    (owner),
      .done_cnt_o (dcnt),
      .err_cnt_o  (ecnt)
   );

   int       tests = 0;
   int       fails = 0;
   int       mptr  = 0;
   int       exp_done = 0;
   int       exp_err  = 0;
   mac_job_t jb[N];

   task automatic chk(input string tag, input logic [159:0] obs,
                      input logic [159:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   function automatic logic [N-1:0] onehot(input int g);
      logic [N-1:0] v;
      v = '0;
      v[g] = 1'b1;
      return v;
   endfunction

   // First valid requester at or after the model pointer, with wrap.
   function automatic int pick(input logic [N-1:0] m);
      for (int i = 0; i < N; i++)
         if (m[(mptr + i) % N]) return (mptr + i) % N;
      return -1;
   endfunction

   task automatic mkjobs(input bit allow_zero);
      for (int r = 0; r < N; r++) begin
         jb[r].a_addr     = $urandom;
         jb[r].b_addr     = $urandom;
         jb[r].c_addr     = $urandom;
         jb[r].d_addr     = $urandom;
         jb[r].len        = 16'($urandom_range(1, 65535));
         if (allow_zero && $urandom_range(0, 3) == 0) jb[r].len = '0;
         jb[r].shift      = 5'($urandom);
         jb[r].simple_mul = 1'($urandom);
         bus.req_job_i[r*JOB_W +: JOB_W] = jb[r];
      end
   endtask

   // One job end to end; dly = BUSY cycle index carrying mac_done
   // (anything >= TO means the MAC never answers).
   task automatic run_txn(input logic [N-1:0] mask, input int dly);
      int g;
      bit err;
      bus.req_valid_i = mask;
      #1;
      g = pick(mask);
      chk("ready_onehot", bus.req_ready_o, onehot(g));
      mptr = (g + 1) % N;
      tick();
      bus.req_valid_i = '0;
      chk("owner", owner, g);
      chk("job_latched", bus.mac_job_o, jb[g]);
      chk("busy", busy, 1);
      chk("ready_low", bus.req_ready_o, 0);
      err = 1'b1;
      if (jb[g].len == 0) begin
         chk("no_start", bus.mac_start_o, 0);
      end else begin
         chk("start", bus.mac_start_o, 1);
         tick();
         for (int k = 0; k < TO + 4; k++) begin
            bus.mac_done_i = (k == dly);
            #1;
            chk("start_once", bus.mac_start_o, 0);
            if (k == dly) begin
               chk("done_no_clr", bus.mac_clear_o, 0);
               err = 1'b0;
               tick();
               bus.mac_done_i = 1'b0;
               break;
            end else if (k == TO - 1) begin
               chk("wd_clr", bus.mac_clear_o, 1);
               tick();
               break;
            end else begin
               chk("busy_no_clr", bus.mac_clear_o, 0);
               tick();
            end
         end
      end
      chk("rsp_valid", bus.rsp_valid_o, onehot(g));
      chk("rsp_err", bus.rsp_err_o, err);
      if (err) exp_err++;
      else exp_done++;
      tick();
      chk("rsp_gone", bus.rsp_valid_o, 0);
      chk("rsp_err_gone", bus.rsp_err_o, 0);
      chk("idle", busy, 0);
      chk("done_cnt", dcnt, exp_done);
      chk("err_cnt", ecnt, exp_err);
   endtask

   initial begin
      int g;
      logic [N-1:0] m;
      rst = 1'b1;
      clr = 1'b0;
      bus.req_valid_i = '0;
      bus.req_job_i   = '0;
      bus.mac_done_i  = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_owner", owner, 0);
      chk("rst_dcnt", dcnt, 0);
      chk("rst_ecnt", ecnt, 0);
      chk("rst_job", bus.mac_job_o, 0);
      chk("rst_rsp", bus.rsp_valid_o, 0);
      chk("rst_start", bus.mac_start_o, 0);
      chk("rst_clear", bus.mac_clear_o, 0);
      chk("rst_ready", bus.req_ready_o, 0);

      // Fair rotation with everybody requesting: 0,1,2,3,0.
      for (int i = 0; i < 5; i++) begin
         mkjobs(1'b0);
         run_txn(4'hF, 4);
      end

      // Single requester, normal completion.
      mkjobs(1'b0);
      run_txn(4'b0100, 10);

      // Illegal zero-length job.
      mkjobs(1'b0);
      jb[1].len = '0;
      bus.req_job_i[1*JOB_W +: JOB_W] = jb[1];
      run_txn(4'b0010, 0);

      // Watchdog abort, then a normal job.
      mkjobs(1'b0);
      run_txn(4'b1001, TO + 10);
      mkjobs(1'b0);
      run_txn(4'b0001, 2);

      // Done exactly on the timeout cycle.
      mkjobs(1'b0);
      run_txn(4'b0110, TO - 1);

      // mac_done while idle is ignored.
      bus.mac_done_i = 1'b1;
      tick();
      bus.mac_done_i = 1'b0;
      chk("idle_done_busy", busy, 0);
      chk("idle_done_cnt", dcnt, exp_done);

      // Soft clear while idle blocks the accept.
      bus.req_valid_i = 4'hF;
      clr = 1'b1;
      #1;
      chk("clr_idle_ready", bus.req_ready_o, 0);
      tick();
      clr = 1'b0;
      bus.req_valid_i = '0;
      chk("clr_idle_busy", busy, 0);

      // Soft clear during BUSY.
      mkjobs(1'b0);
      m = 4'b1010;
      bus.req_valid_i = m;
      #1;
      g = pick(m);
      chk("c6_ready", bus.req_ready_o, onehot(g));
      mptr = (g + 1) % N;
      tick();
      bus.req_valid_i = '0;
      chk("c6_start", bus.mac_start_o, 1);
      tick();
      tick();
      tick();
      clr = 1'b1;
      #1;
      chk("c6_clr", bus.mac_clear_o, 1);
      chk("c6_norsp", bus.rsp_valid_o, 0);
      tick();
      clr = 1'b0;
      #1;
      chk("c6_idle", busy, 0);
      chk("c6_norsp2", bus.rsp_valid_o, 0);
      chk("c6_nomclr", bus.mac_clear_o, 0);
      chk("c6_dcnt", dcnt, exp_done);
      chk("c6_ecnt", ecnt, exp_err);
      chk("c6_job", bus.mac_job_o, jb[g]);
      chk("c6_owner", owner, g);
      mkjobs(1'b0);
      run_txn(4'hF, 3);

      // Random traffic against the model.
      for (int i = 0; i < 40; i++) begin
         mkjobs(1'b1);
         run_txn(N'($urandom_range(1, 15)), $urandom_range(0, 19));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
